// File: rtl/slot_drain.sv
// Round-robin drainer of occupied slots with a valid/ready offer port.
// Define SLOT_DRAIN_CNT_EN to build the occupancy counter behind count_o.
module slot_drain #(
  parameter int W = 32,
  localparam int IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          set_vld_i,
  input  logic [IW-1:0] set_idx_i,
  input  logic          flush_i,
  input  logic          deq_rdy_i,
  output logic          deq_vld_o,
  output logic [IW-1:0] deq_idx_o,
  output logic [W-1:0]  deq_oh_o,
  output logic [W-1:0]  occ_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [IW:0]   count_o
);

  if (W < 2) begin : g_w_chk
    $error("slot_drain: W must be >= 2");
  end

  typedef enum logic {IDLE, OFFER} st_e;

  st_e           state_q;
  logic [W-1:0]  occ_q, occ_d;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] off_idx_q;

  logic          hs;
  logic [W-1:0]  set_vec;
  logic          set_ok;
  logic [W-1:0]  off_oh;
  logic [W-1:0]  hs_mask;
  logic [W-1:0]  occ_clr;
  logic [W-1:0]  rem;
  logic [IW-1:0] nxt_ptr;

  // Circular ascending search from p, p included.
  function automatic logic [IW-1:0] search(
    input logic [W-1:0]  v,
    input logic [IW-1:0] p
  );
    logic [IW-1:0] lo, hi;
    logic          hf;
    lo = '0;
    hi = '0;
    hf = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) begin
        lo = IW'(i);
        if (IW'(i) >= p) begin
          hi = IW'(i);
          hf = 1'b1;
        end
      end
    end
    return hf ? hi : lo;
  endfunction

  always_comb begin
    set_vec = '0;
    for (int i = 0; i < W; i++) begin
      set_vec[i] = set_vld_i && (set_idx_i == IW'(i));
    end
  end

  assign set_ok  = |set_vec;
  assign hs      = (state_q == OFFER) & deq_rdy_i;
  assign off_oh  = W'(1) << off_idx_q;
  assign hs_mask = hs ? off_oh : '0;
  assign occ_clr = occ_q & ~hs_mask;
  assign rem     = occ_q & ~off_oh;
  assign nxt_ptr = (off_idx_q == IW'(W - 1)) ? '0 : off_idx_q + IW'(1);
  assign occ_d   = flush_i ? '0 : (occ_clr | set_vec);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      occ_q     <= '0;
      ptr_q     <= '0;
      off_idx_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (flush_i) begin
        state_q <= IDLE;
        ptr_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (|occ_q) begin
              off_idx_q <= search(occ_q, ptr_q);
              state_q   <= OFFER;
            end
          end
          OFFER: begin
            if (deq_rdy_i) begin
              ptr_q <= nxt_ptr;
              if (|rem) begin
                off_idx_q <= search(rem, nxt_ptr);
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign deq_vld_o = (state_q == OFFER);
  assign deq_idx_o = deq_vld_o ? off_idx_q : '0;
  assign deq_oh_o  = deq_vld_o ? off_oh : '0;
  assign occ_o     = occ_q;
  assign empty_o   = ~|occ_q;
  assign full_o    = &occ_q;

  // Setting a slot still occupied after this cycle's accept is a producer bug.
  a_set_free: assert property (@(posedge clk) disable iff (!arst_n)
    !(set_ok && !flush_i && |(set_vec & occ_clr)));

`ifdef SLOT_DRAIN_CNT_EN
  logic [IW:0] count_q;
  logic        set_acc;

  assign set_acc = |(set_vec & ~occ_clr);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + (IW+1)'(set_acc) - (IW+1)'(hs);
    end
  end

  assign count_o = count_q;

  a_count: assert property (@(posedge clk) disable iff (!arst_n)
    32'(count_q) == $countones(occ_q));
`else
  assign count_o = '0;
`endif

endmodule

// File: tb/tb_slot_drain.sv
// Directed bench for slot_drain with a per-cycle reference model.
module tb_slot_drain;

  localparam int W = 32;

  logic          clk;
  logic          arst_n;
  logic          set_vld_i;
  logic [4:0]    set_idx_i;
  logic          flush_i;
  logic          deq_rdy_i;
  logic          deq_vld_o;
  logic [4:0]    deq_idx_o;
  logic [W-1:0]  deq_oh_o;
  logic [W-1:0]  occ_o;
  logic          empty_o;
  logic          full_o;
  logic [5:0]    count_o;

  int checks = 0;
  int errors = 0;

  slot_drain #(.W(W)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .set_vld_i (set_vld_i),
    .set_idx_i (set_idx_i),
    .flush_i   (flush_i),
    .deq_rdy_i (deq_rdy_i),
    .deq_vld_o (deq_vld_o),
    .deq_idx_o (deq_idx_o),
    .deq_oh_o  (deq_oh_o),
    .occ_o     (occ_o),
    .empty_o   (empty_o),
    .full_o    (full_o),
    .count_o   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference model: table, pointer, current offer.
  bit [31:0] m_occ;
  int        m_ptr;
  bit        m_vld;
  int        m_off;
  int        acc[$];

  function automatic int srch(input bit [31:0] v, input int p);
    for (int k = 0; k < W; k++) begin
      if (v[(p + k) % W]) return (p + k) % W;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    bit [31:0] nx;
    bit [31:0] rest;
    if (!arst_n) begin
      m_occ = '0;
      m_ptr = 0;
      m_vld = 1'b0;
      m_off = 0;
    end else begin
      if (deq_vld_o && deq_rdy_i) acc.push_back(int'(deq_idx_o));
      if (flush_i) begin
        m_occ = '0;
        m_ptr = 0;
        m_vld = 1'b0;
      end else begin
        nx = m_occ;
        if (!m_vld) begin
          if (m_occ != 0) begin
            m_off = srch(m_occ, m_ptr);
            m_vld = 1'b1;
          end
        end else if (deq_rdy_i) begin
          rest = m_occ;
          rest[m_off] = 1'b0;
          nx[m_off] = 1'b0;
          m_ptr = (m_off + 1) % W;
          if (rest != 0) m_off = srch(rest, m_ptr);
          else m_vld = 1'b0;
        end
        if (set_vld_i) nx[set_idx_i] = 1'b1;
        m_occ = nx;
      end
    end
  end

  function automatic int exp_cnt(input bit [31:0] v);
`ifdef SLOT_DRAIN_CNT_EN
    return $countones(v);
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (arst_n) begin
      chk("vld", deq_vld_o, m_vld);
      if (m_vld) begin
        chk("idx", deq_idx_o, m_off);
        chk("oh", deq_oh_o, 32'd1 << m_off);
      end
      chk("occ", occ_o, m_occ);
      chk("empty", empty_o, m_occ == 0);
      chk("full", full_o, m_occ == '1);
      chk("count", count_o, exp_cnt(m_occ));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set1(input int idx);
    set_vld_i = 1'b1;
    set_idx_i = 5'(idx);
    step();
    set_vld_i = 1'b0;
  endtask

  initial begin
    arst_n    = 1'b0;
    set_vld_i = 1'b0;
    set_idx_i = '0;
    flush_i   = 1'b0;
    deq_rdy_i = 1'b0;
    repeat (2) step();
    chk("rst_vld", deq_vld_o, 0);
    chk("rst_idx", deq_idx_o, 0);
    chk("rst_oh", deq_oh_o, 0);
    chk("rst_occ", occ_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_count", count_o, 0);
    arst_n = 1'b1;

    // set 5 -> offered two edges later
    set1(5);
    chk("s5_vld_t1", deq_vld_o, 0);
    step();
    chk("s5_vld", deq_vld_o, 1);
    chk("s5_idx", deq_idx_o, 5);
    chk("s5_oh", deq_oh_o, 32'h20);
    deq_rdy_i = 1'b1;
    step();
    deq_rdy_i = 1'b0;
    chk("s5_empty", empty_o, 1);
    chk("s5_ptr", m_ptr, 6);
    set1(9);
    step();
    deq_rdy_i = 1'b1;
    step();
    deq_rdy_i = 1'b0;
    chk("p10_ptr", m_ptr, 10);
    chk("p10_acc", {acc[0][7:0], acc[1][7:0]}, 16'h0509);
    acc.delete();

    // ptr 10: 30,3,9 back to back
    set1(30);
    set1(3);
    set1(9);
    deq_rdy_i = 1'b1;
    repeat (3) step();
    deq_rdy_i = 1'b0;
    chk("rr_vld_end", deq_vld_o, 0);
    chk("rr_n", acc.size(), 3);
    chk("rr_ord", {acc[0][7:0], acc[1][7:0], acc[2][7:0]}, 24'h1E0309);
    acc.delete();

    // wrap at 31
    set1(31);
    step();
    deq_rdy_i = 1'b1;
    step();
    deq_rdy_i = 1'b0;
    chk("wrap_ptr", m_ptr, 0);
    set1(0);
    set1(31);
    deq_rdy_i = 1'b1;
    repeat (2) step();
    deq_rdy_i = 1'b0;
    chk("wrap_ord", {acc[0][7:0], acc[1][7:0], acc[2][7:0]}, 24'h1F001F);
    acc.delete();

    // stall: offer 4 held while slot 1 appears
    set1(4);
    step();
    set1(1);
    chk("stall_idx0", deq_idx_o, 4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_idx", deq_idx_o, 4);
    end
    chk("stall_occ", occ_o, 32'h12);
    deq_rdy_i = 1'b1;
    repeat (2) step();
    deq_rdy_i = 1'b0;
    chk("stall_ord", {acc[0][7:0], acc[1][7:0]}, 16'h0401);
    acc.delete();

    // fill, then flush with accept and a dropped set
    for (int i = 0; i < W; i++) set1(i);
    chk("fill_full", full_o, 1);
    chk("fill_occ", occ_o, 32'hFFFF_FFFF);
`ifdef SLOT_DRAIN_CNT_EN
    chk("fill_cnt", count_o, 32);
`endif
    flush_i   = 1'b1;
    deq_rdy_i = 1'b1;
    set_vld_i = 1'b1;
    set_idx_i = 5'd7;
    step();
    flush_i   = 1'b0;
    deq_rdy_i = 1'b0;
    set_vld_i = 1'b0;
    chk("fl_occ", occ_o, 0);
    chk("fl_vld", deq_vld_o, 0);
    chk("fl_empty", empty_o, 1);
    chk("fl_cnt", count_o, 0);
    repeat (2) step();
    chk("fl_no7", occ_o[7], 0);
    chk("fl_vld2", deq_vld_o, 0);
    acc.delete();

    // set and accept 12 in one cycle
    set1(12);
    set1(20);
    set1(2);
    chk("sa_idx", deq_idx_o, 12);
    deq_rdy_i = 1'b1;
    set1(12);
    chk("sa_bit12", occ_o[12], 1);
    chk("sa_occ", occ_o, 32'h0010_1004);
    repeat (3) step();
    deq_rdy_i = 1'b0;
    chk("sa_n", acc.size(), 4);
    chk("sa_ord", {acc[0][7:0], acc[1][7:0], acc[2][7:0], acc[3][7:0]},
        32'h0C14020C);
    chk("sa_empty", empty_o, 1);
    acc.delete();

    // async reset mid-offer
    set1(8);
    step();
    chk("ar_vld_pre", deq_vld_o, 1);
    #2 arst_n = 1'b0;
    #1;
    chk("ar_vld", deq_vld_o, 0);
    chk("ar_occ", occ_o, 0);
    chk("ar_empty", empty_o, 1);
    step();
    arst_n = 1'b1;
    repeat (2) step();
    chk("ar_idle", deq_vld_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
